// File: rtl/rom_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rom_arb_pkg
// Description : Shared defaults and constants for the ROM arbiter. This
//               package holds the default sizes and ROM latency, the
//               requester index names, and the index-width helper used by
//               the arbiter and its winner picker.
// Revision    : 1.0 - initial release
// ============================================================================
package rom_arb_pkg;

    // Default geometry
    localparam int c_NREQ    = 3;
    localparam int c_AW      = 15;
    localparam int c_DW      = 16;
    localparam int c_ROM_LAT = 1;   // legal range 1..4

    // Requester slots on the shared ROM
    localparam int REQ_BG  = 0;     // background
    localparam int REQ_CAR = 1;     // player car
    localparam int REQ_OBS = 2;     // obstacle

    // Width of a requester index; at least one bit even for a single requester
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rom_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational winner search. The search starts at
//               last_winner+1 and wraps from NREQ-1 to 0. With last_winner
//               tied to NREQ-1, the search degenerates to fixed priority with
//               the lowest index winning.
// Ports       : req         - request vector
//               last_winner - index granted most recently
//               win         - one-hot winner (all zero when no request)
//               win_idx     - binary index of the winner (0 when no request)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import rom_arb_pkg::*;
#(
    parameter int NREQ = c_NREQ,
    parameter int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_winner,
    output logic [NREQ-1:0] win,
    output logic [IW-1:0]   win_idx
);

    logic w_found;
    int   w_cand;

    always_comb begin
        win     = '0;
        win_idx = '0;
        w_found = 1'b0;
        w_cand  = 0;
        for (int k = 1; k <= NREQ; k++) begin
            // Rotating candidate; a wrap by subtraction avoids a general modulo
            w_cand = int'(last_winner) + k;
            if (w_cand >= NREQ) begin
                w_cand = w_cand - NREQ;
            end
            if (!w_found && req[w_cand]) begin
                w_found      = 1'b1;
                win[w_cand]  = 1'b1;
                win_idx      = IW'(w_cand);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rom_arbiter
// Description : This module shares one block ROM between NREQ requesters.
//               It grants at most one request per cycle. The grant and the
//               ROM address are registered. A tag pipeline of depth
//               ROM_LAT+1 steers the returning ROM data back to the granted
//               requester. Responses therefore return in grant order,
//               ROM_LAT+1 cycles after the grant.
// Config      : `define ROM_ARB_RR_EN selects round-robin arbitration. When
//               this macro is undefined, the arbiter uses fixed priority,
//               where the lowest index wins, and no last-winner register is
//               built.
// Ports       : clk      - clock, rising edge
//               clr      - asynchronous active-high reset
//               req      - per-requester level request
//               addr     - packed request addresses, requester i at [i*AW +: AW]
//               gnt      - one-hot grant pulse (registered)
//               rom_addr - ROM address (registered, holds when idle)
//               rom_data - ROM read data, valid ROM_LAT cycles after rom_addr
//               rd_valid - one-hot response strobe (registered)
//               rd_data  - response data (registered, holds when idle)
// Revision    : 1.0 - initial release
// ============================================================================
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NREQ    = c_NREQ,
    parameter int AW      = c_AW,
    parameter int DW      = c_DW,
    parameter int ROM_LAT = c_ROM_LAT   // 1..4
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] addr,
    output logic [NREQ-1:0]    gnt,
    output logic [AW-1:0]      rom_addr,
    input  logic [DW-1:0]      rom_data,
    output logic [NREQ-1:0]    rd_valid,
    output logic [DW-1:0]      rd_data
);

    localparam int              c_IW       = idx_width(NREQ);
    localparam logic [c_IW-1:0] c_LAST_RST = c_IW'(NREQ - 1);  // requester 0 wins first
    localparam logic [NREQ-1:0] c_ONE      = NREQ'(1);

    logic [NREQ-1:0] w_win;
    logic [c_IW-1:0] w_win_idx;
    logic            w_any;
    logic [c_IW-1:0] w_last_winner;

    logic [NREQ-1:0] r_gnt;
    logic [AW-1:0]   r_rom_addr;
    logic [NREQ-1:0] r_rd_valid;
    logic [DW-1:0]   r_rd_data;

    // Tag stage k describes the grant issued k cycles ago. Stage ROM_LAT
    // lines up with rom_data for that grant.
    logic [ROM_LAT:0]            r_tag_vld;
    logic [ROM_LAT:0][c_IW-1:0]  r_tag_idx;

`ifdef ROM_ARB_RR_EN
    logic [c_IW-1:0] r_last_winner;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_last_winner <= c_LAST_RST;
        end else if (w_any) begin
            r_last_winner <= w_win_idx;
        end
    end

    assign w_last_winner = r_last_winner;
`else
    assign w_last_winner = c_LAST_RST;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IW   (c_IW)
    ) u_pick (
        .req         (req),
        .last_winner (w_last_winner),
        .win         (w_win),
        .win_idx     (w_win_idx)
    );

    assign w_any = |w_win;

    // Grant and ROM address; the address holds across idle cycles
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_gnt      <= '0;
            r_rom_addr <= '0;
        end else begin
            r_gnt <= w_win;
            if (w_any) begin
                r_rom_addr <= addr[int'(w_win_idx)*AW +: AW];
            end
        end
    end

    // Tag pipeline; the index travels even when invalid, because only the
    // valid bit qualifies it
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_tag_vld <= '0;
            r_tag_idx <= '0;
        end else begin
            r_tag_vld <= {r_tag_vld[ROM_LAT-1:0], w_any};
            r_tag_idx <= {r_tag_idx[ROM_LAT-1:0], w_win_idx};
        end
    end

    // Response register; the data holds its last value between responses
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_rd_valid <= '0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= r_tag_vld[ROM_LAT] ? (c_ONE << r_tag_idx[ROM_LAT]) : '0;
            if (r_tag_vld[ROM_LAT]) begin
                r_rd_data <= rom_data;
            end
        end
    end

    assign gnt      = r_gnt;
    assign rom_addr = r_rom_addr;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_rom_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rom_arbiter
// Description : Self-checking bench for rom_arbiter. It drives two instances
//               that share the same inputs: one with ROM_LAT=1 and one with
//               ROM_LAT=3. Each instance has its own ROM model. The bench
//               follows the same arbitration mode as the RTL
//               (ROM_ARB_RR_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_arbiter;
    import rom_arb_pkg::*;

    localparam int NREQ = 3;
    localparam int AW   = 15;
    localparam int DW   = 16;

    localparam logic [NREQ-1:0] BG  = NREQ'(1) << REQ_BG;
    localparam logic [NREQ-1:0] CAR = NREQ'(1) << REQ_CAR;
    localparam logic [NREQ-1:0] OBS = NREQ'(1) << REQ_OBS;
    localparam logic [NREQ-1:0] ALL = BG | CAR | OBS;

    localparam logic [AW-1:0] A0 = 15'h0100;
    localparam logic [AW-1:0] A1 = 15'h1234;
    localparam logic [AW-1:0] A2 = 15'h7FFF;

    logic              clk = 1'b0;
    logic              clr;
    logic [NREQ-1:0]   req;
    logic [NREQ*AW-1:0] addr;

    logic [NREQ-1:0] gnt1, rv1, gnt3, rv3;
    logic [AW-1:0]   ra1, ra3;
    logic [DW-1:0]   rd1, rd3, rom1, rom3;

    always #5 clk = ~clk;

    rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .ROM_LAT(1)) u_dut1 (
        .clk(clk), .clr(clr), .req(req), .addr(addr), .gnt(gnt1),
        .rom_addr(ra1), .rom_data(rom1), .rd_valid(rv1), .rd_data(rd1)
    );

    rom_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .ROM_LAT(3)) u_dut3 (
        .clk(clk), .clr(clr), .req(req), .addr(addr), .gnt(gnt3),
        .rom_addr(ra3), .rom_data(rom3), .rd_valid(rv3), .rd_data(rd3)
    );

    // ROM contents: a fixed scramble of the address
    function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
        return {a[7:0], a[14:7]} ^ 16'hA5C3;
    endfunction

    // ROM models: registered read with latency 1 and 3
    logic [AW-1:0] rp1_0, rp3_0, rp3_1, rp3_2;
    always @(posedge clk) begin
        rp1_0 <= ra1;
        rp3_0 <= ra3;
        rp3_1 <= rp3_0;
        rp3_2 <= rp3_1;
    end
    assign rom1 = rom_f(rp1_0);
    assign rom3 = rom_f(rp3_2);

    // ---------------------------------------------------------------- model
    typedef struct {
        int              due;
        logic [NREQ-1:0] oh;
        logic [DW-1:0]   data;
    } resp_t;

    resp_t q1[$];
    resp_t q3[$];
    int    edge_n = 0;
`ifdef ROM_ARB_RR_EN
    int    last_w = NREQ - 1;
`endif
    logic [NREQ-1:0] e_gnt, e_rv1, e_rv3;
    logic [AW-1:0]   e_ra;
    logic [DW-1:0]   e_rd1, e_rd3;

    int checks = 0;
    int errors = 0;

    function automatic int pick(input logic [NREQ-1:0] r);
`ifdef ROM_ARB_RR_EN
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last_w + k) % NREQ]) return (last_w + k) % NREQ;
        end
`else
        for (int i = 0; i < NREQ; i++) begin
            if (r[i]) return i;
        end
`endif
        return -1;
    endfunction

    // Advance the model by one rising edge using the inputs present at that edge
    task automatic model_edge();
        int    w;
        resp_t r;
        edge_n++;
        e_rv1 = '0;
        e_rv3 = '0;
        if (clr) begin
            q1.delete();
            q3.delete();
            e_gnt = '0;
            e_ra  = '0;
            e_rd1 = '0;
            e_rd3 = '0;
`ifdef ROM_ARB_RR_EN
            last_w = NREQ - 1;
`endif
            return;
        end
        w = pick(req);
        e_gnt = '0;
        if (w >= 0) begin
            e_gnt  = NREQ'(1) << w;
            e_ra   = addr[w*AW +: AW];
            r.oh   = e_gnt;
            r.data = rom_f(e_ra);
            r.due  = edge_n + 1 + 1;
            q1.push_back(r);
            r.due  = edge_n + 3 + 1;
            q3.push_back(r);
`ifdef ROM_ARB_RR_EN
            last_w = w;
`endif
        end
        if (q1.size() > 0 && q1[0].due == edge_n) begin
            e_rv1 = q1[0].oh;
            e_rd1 = q1[0].data;
            void'(q1.pop_front());
        end
        if (q3.size() > 0 && q3[0].due == edge_n) begin
            e_rv3 = q3[0].oh;
            e_rd3 = q3[0].data;
            void'(q3.pop_front());
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic check_all();
        chk("gnt_lat1",  32'(gnt1), 32'(e_gnt));
        chk("gnt_lat3",  32'(gnt3), 32'(e_gnt));
        chk("rom_addr1", 32'(ra1),  32'(e_ra));
        chk("rom_addr3", 32'(ra3),  32'(e_ra));
        chk("rd_valid1", 32'(rv1),  32'(e_rv1));
        chk("rd_data1",  32'(rd1),  32'(e_rd1));
        chk("rd_valid3", 32'(rv3),  32'(e_rv3));
        chk("rd_data3",  32'(rd3),  32'(e_rd3));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    // ---------------------------------------------------------------- table
    typedef struct {
        logic            clr;
        logic [NREQ-1:0] req;
        logic [AW-1:0]   a0, a1, a2;
        logic [NREQ-1:0] gnt;
        logic [AW-1:0]   ra;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic c, input logic [NREQ-1:0] r,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [AW-1:0] a2, input logic [NREQ-1:0] g,
                       input logic [AW-1:0] ra);
        vec_t v;
        v.clr = c; v.req = r; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.gnt = g; v.ra = ra;
        tbl.push_back(v);
    endtask

    logic [NREQ-1:0] g_hist [4];

    initial begin
        clr  = 1'b1;
        req  = '0;
        addr = '0;

        // Reset, then a single grant and its responses at both latencies
        add(1, '0, A0, A1, A2, '0, '0);
        add(0, BG, A0, A1, A2, BG, A0);
        for (int i = 0; i < 4; i++) add(0, '0, A0, A1, A2, '0, A0);
        add(1, '0, A0, A1, A2, '0, '0);
`ifdef ROM_ARB_RR_EN
        for (int i = 0; i < 2; i++) begin
            add(0, ALL, A0, A1, A2, BG,  A0);
            add(0, ALL, A0, A1, A2, CAR, A1);
            add(0, ALL, A0, A1, A2, OBS, A2);
        end
        for (int i = 0; i < 2; i++) begin
            add(0, CAR | OBS, A0, A1, A2, CAR, A1);
            add(0, CAR | OBS, A0, A1, A2, OBS, A2);
        end
        for (int i = 0; i < 2; i++) begin
            add(0, BG | OBS, A0, A1, A2, BG,  A0);
            add(0, BG | OBS, A0, A1, A2, OBS, A2);
        end
`else
        for (int i = 0; i < 6; i++) add(0, ALL,       A0, A1, A2, BG,  A0);
        for (int i = 0; i < 4; i++) add(0, CAR | OBS, A0, A1, A2, CAR, A1);
        for (int i = 0; i < 4; i++) add(0, BG | OBS,  A0, A1, A2, BG,  A0);
`endif
        // Back-to-back grants at the address extremes
        add(0, BG,  15'h0000, A1, A2,       BG,  15'h0000);
        add(0, OBS, 15'h0000, A1, 15'h7FFF, OBS, 15'h7FFF);
        for (int i = 0; i < 5; i++) add(0, '0, 15'h0000, A1, 15'h7FFF, '0, 15'h7FFF);

        for (int k = 0; k < 4; k++) g_hist[k] = '0;

        foreach (tbl[i]) begin
            clr  = tbl[i].clr;
            req  = tbl[i].req;
            addr = {tbl[i].a2, tbl[i].a1, tbl[i].a0};
            step();
            chk("tbl_gnt",  32'(gnt1), 32'(tbl[i].gnt));
            chk("tbl_addr", 32'(ra1),  32'(tbl[i].ra));
            // Grant k edges back predicts the strobe at latency k-1
            chk("tbl_rv1", 32'(rv1), tbl[i].clr ? 32'd0 : 32'(g_hist[1]));
            chk("tbl_rv3", 32'(rv3), tbl[i].clr ? 32'd0 : 32'(g_hist[3]));
            if (tbl[i].clr) begin
                for (int k = 0; k < 4; k++) g_hist[k] = '0;
            end else begin
                for (int k = 3; k > 0; k--) g_hist[k] = g_hist[k-1];
                g_hist[0] = tbl[i].gnt;
            end
        end

        // A single requester held high is granted every cycle
        clr = 1'b0;
        req = CAR;
        addr = {A2, A1, A0};
        for (int i = 0; i < 4; i++) begin
            step();
            chk("single_req_gnt", 32'(gnt1), 32'(CAR));
        end

        // Reset with grants in flight: outputs clear at once, nothing returns
        req = ALL;
        for (int i = 0; i < 3; i++) step();
        clr = 1'b1;
        #1;
        chk("async_gnt1", 32'(gnt1), 32'd0);
        chk("async_rv1",  32'(rv1),  32'd0);
        chk("async_ra1",  32'(ra1),  32'd0);
        chk("async_rd1",  32'(rd1),  32'd0);
        chk("async_gnt3", 32'(gnt3), 32'd0);
        chk("async_rv3",  32'(rv3),  32'd0);
        chk("async_ra3",  32'(ra3),  32'd0);
        chk("async_rd3",  32'(rd3),  32'd0);
        step();
        clr = 1'b0;
        req = '0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("post_clr_rv1", 32'(rv1), 32'd0);
            chk("post_clr_rv3", 32'(rv3), 32'd0);
        end

        // Random traffic against the model, with occasional resets
        for (int i = 0; i < 400; i++) begin
            clr  = ($urandom_range(0, 39) == 0);
            req  = NREQ'($urandom_range(0, 7));
            addr = {AW'($urandom), AW'($urandom), AW'($urandom)};
            step();
        end
        clr = 1'b0;
        req = '0;
        for (int i = 0; i < 6; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
